commit_controller: RTL and testbench

COMMIT_CONTROLLER -- requirements
Module: commit_controller

---
 rtl/commit_controller_pkg.sv | 20 ++
 rtl/commit_controller_perf_counter.sv | 29 ++
 rtl/commit_controller.sv | 147 ++++++++++++++
 tb/tb_commit_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/commit_controller_pkg.sv
// Shared definitions for the commit controller: head instruction type
// encodings, the default ROB index width and the controller state encoding.
package commit_controller_pkg;

    localparam int ROB_IDX_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        HT_ALU    = 2'd0,   // ALU or LOAD: register write only
        HT_STORE  = 2'd1,   // memory release, no register write
        HT_BRANCH = 2'd2,
        HT_JALR   = 2'd3
    } head_type_e;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_STORE_WAIT = 2'd1,
        ST_FLUSH      = 2'd2
    } state_e;

endpackage

// File: rtl/commit_controller_perf_counter.sv
// perf_counter: free-running event counter, wraps at 2^WIDTH.
//   clk, rst : clock, synchronous active-high reset (clears count)
//   inc      : count one event this cycle
//   count    : current count
module perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc) count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/commit_controller.sv
// commit_controller: in-order retirement of the ROB head.
//   Inputs : clk, rst (sync, active-high), rdy (global enable/freeze),
//            head_* (ROB head entry), st_done (store finished in memory).
//   Outputs: head_pop (retire pulse), rf_valid/rf_index/rf_rd/rf_value
//            (register write), st_commit (store release, held until st_done),
//            flush/redirect_pc (mispredict recovery), commit_count.
// All outputs are registered; a ready head is committed one cycle after it
// is sampled.
module commit_controller
    import commit_controller_pkg::*;
#(
    parameter int ROB_IDX_W = ROB_IDX_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 head_valid,
    input  logic                 head_ready,
    input  logic [ROB_IDX_W-1:0] head_index,
    input  logic [1:0]           head_type,
    input  logic [4:0]           head_rd,
    input  logic [31:0]          head_value,
    input  logic                 head_mispredict,
    input  logic [31:0]          head_target,
    input  logic                 st_done,
    output logic                 head_pop,
    output logic                 rf_valid,
    output logic [ROB_IDX_W-1:0] rf_index,
    output logic [4:0]           rf_rd,
    output logic [31:0]          rf_value,
    output logic                 st_commit,
    output logic                 flush,
    output logic [31:0]          redirect_pc,
    output logic [31:0]          commit_count
);

    state_e                 state_q,       state_d;
    logic                   head_pop_q,    head_pop_d;
    logic                   rf_valid_q,    rf_valid_d;
    logic [ROB_IDX_W-1:0]   rf_index_q,    rf_index_d;
    logic [4:0]             rf_rd_q,       rf_rd_d;
    logic [31:0]            rf_value_q,    rf_value_d;
    logic                   st_commit_q,   st_commit_d;
    logic                   flush_q,       flush_d;
    logic [31:0]            redirect_pc_q, redirect_pc_d;
    logic [ROB_IDX_W-1:0]   last_idx_q,    last_idx_d;
    logic                   hazard;

    // While head_pop is visible the ROB has not yet advanced its head, so the
    // entry just retired is still presented; skip it.
    assign hazard = head_pop_q && (head_index == last_idx_q);

    always_comb begin
        state_d       = state_q;
        head_pop_d    = 1'b0;
        rf_valid_d    = 1'b0;
        flush_d       = 1'b0;
        st_commit_d   = st_commit_q;
        rf_index_d    = rf_index_q;
        rf_rd_d       = rf_rd_q;
        rf_value_d    = rf_value_q;
        redirect_pc_d = redirect_pc_q;
        last_idx_d    = last_idx_q;
        if (!rdy) begin
            // Freeze: strobes keep their current level too.
            head_pop_d = head_pop_q;
            rf_valid_d = rf_valid_q;
            flush_d    = flush_q;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (head_valid && head_ready && !hazard) begin
                        last_idx_d = head_index;
                        if (head_type_e'(head_type) == HT_STORE) begin
                            st_commit_d = 1'b1;
                            state_d     = ST_STORE_WAIT;
                        end else begin
                            rf_valid_d = 1'b1;
                            head_pop_d = 1'b1;
                            rf_index_d = head_index;
                            rf_rd_d    = head_rd;
                            rf_value_d = head_value;
                            if (head_type_e'(head_type) != HT_ALU && head_mispredict) begin
                                flush_d       = 1'b1;
                                redirect_pc_d = head_target;
                                state_d       = ST_FLUSH;
                            end
                        end
                    end
                end
                ST_STORE_WAIT: begin
                    if (st_done) begin
                        st_commit_d = 1'b0;
                        head_pop_d  = 1'b1;
                        state_d     = ST_RUN;
                    end
                end
                ST_FLUSH: state_d = ST_RUN;   // one dead cycle, head ignored
                default:  state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            head_pop_q    <= 1'b0;
            rf_valid_q    <= 1'b0;
            rf_index_q    <= '0;
            rf_rd_q       <= '0;
            rf_value_q    <= '0;
            st_commit_q   <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
            last_idx_q    <= '0;
        end else begin
            state_q       <= state_d;
            head_pop_q    <= head_pop_d;
            rf_valid_q    <= rf_valid_d;
            rf_index_q    <= rf_index_d;
            rf_rd_q       <= rf_rd_d;
            rf_value_q    <= rf_value_d;
            st_commit_q   <= st_commit_d;
            flush_q       <= flush_d;
            redirect_pc_q <= redirect_pc_d;
            last_idx_q    <= last_idx_d;
        end
    end

    // Counter advances on the same edge head_pop rises, so both appear together.
    perf_counter #(.WIDTH(32)) u_retire_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (rdy && head_pop_d),
        .count (commit_count)
    );

    assign head_pop    = head_pop_q;
    assign rf_valid    = rf_valid_q;
    assign rf_index    = rf_index_q;
    assign rf_rd       = rf_rd_q;
    assign rf_value    = rf_value_q;
    assign st_commit   = st_commit_q;
    assign flush       = flush_q;
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_commit_controller.sv
// Directed scenarios followed by randomized traffic, checked every cycle
// against a behavioural retirement model.
module tb_commit_controller;

    logic        clk, rst, rdy;
    logic        head_valid, head_ready, head_mispredict, st_done;
    logic [5:0]  head_index;
    logic [1:0]  head_type;
    logic [4:0]  head_rd;
    logic [31:0] head_value, head_target;
    logic        head_pop, rf_valid, st_commit, flush;
    logic [5:0]  rf_index;
    logic [4:0]  rf_rd;
    logic [31:0] rf_value, redirect_pc, commit_count;

    int n_tests = 0;
    int n_fail  = 0;

    commit_controller #(.ROB_IDX_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .head_valid(head_valid), .head_ready(head_ready), .head_index(head_index),
        .head_type(head_type), .head_rd(head_rd), .head_value(head_value),
        .head_mispredict(head_mispredict), .head_target(head_target),
        .st_done(st_done), .head_pop(head_pop), .rf_valid(rf_valid),
        .rf_index(rf_index), .rf_rd(rf_rd), .rf_value(rf_value),
        .st_commit(st_commit), .flush(flush), .redirect_pc(redirect_pc),
        .commit_count(commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: what the retirement stage should be showing.
    bit          m_pop, m_rfv, m_flush, m_stc;
    bit          m_store_pending, m_flush_gap;
    logic [5:0]  m_idx, m_last;
    logic [4:0]  m_rd;
    logic [31:0] m_val, m_pc, m_count;

    task automatic model_step();
        bit prev_pop;
        if (rst) begin
            m_pop = 0; m_rfv = 0; m_flush = 0; m_stc = 0;
            m_store_pending = 0; m_flush_gap = 0;
            m_idx = 0; m_last = 0; m_rd = 0; m_val = 0; m_pc = 0; m_count = 0;
            return;
        end
        if (!rdy) return;
        prev_pop = m_pop;
        m_pop = 0; m_rfv = 0; m_flush = 0;
        if (m_flush_gap) begin
            m_flush_gap = 0;
        end else if (m_store_pending) begin
            if (st_done) begin
                m_store_pending = 0; m_stc = 0; m_pop = 1;
            end
        end else if (head_valid && head_ready && !(prev_pop && head_index == m_last)) begin
            m_last = head_index;
            if (head_type == 2'd1) begin
                m_store_pending = 1; m_stc = 1;
            end else begin
                m_rfv = 1; m_pop = 1;
                m_idx = head_index; m_rd = head_rd; m_val = head_value;
                if (head_type >= 2'd2 && head_mispredict) begin
                    m_flush = 1; m_pc = head_target; m_flush_gap = 1;
                end
            end
        end
        if (m_pop) m_count = m_count + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("m_head_pop",    {31'd0, head_pop},  {31'd0, m_pop});
        chk("m_rf_valid",    {31'd0, rf_valid},  {31'd0, m_rfv});
        chk("m_flush",       {31'd0, flush},     {31'd0, m_flush});
        chk("m_st_commit",   {31'd0, st_commit}, {31'd0, m_stc});
        chk("m_commit_count", commit_count, m_count);
        chk("m_rf_index",    {26'd0, rf_index},  {26'd0, m_idx});
        chk("m_rf_rd",       {27'd0, rf_rd},     {27'd0, m_rd});
        chk("m_rf_value",    rf_value, m_val);
        chk("m_redirect_pc", redirect_pc, m_pc);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic set_head(input bit v, input logic [5:0] idx, input logic [1:0] t,
                            input logic [4:0] rd, input logic [31:0] val,
                            input bit mis, input logic [31:0] tgt);
        head_valid = v; head_ready = v; head_index = idx; head_type = t;
        head_rd = rd; head_value = val; head_mispredict = mis; head_target = tgt;
    endtask

    initial begin
        int stc_cnt, rfv_seen;
        rst = 1; rdy = 1; st_done = 0;
        set_head(0, 0, 0, 0, 0, 0, 0);

        // Reset state
        tick();
        chk("rst_pop", {31'd0, head_pop}, 32'd0);
        chk("rst_rfv", {31'd0, rf_valid}, 32'd0);
        chk("rst_count", commit_count, 32'd0);
        chk("rst_pc", redirect_pc, 32'd0);
        rst = 0;

        // ALU commit, then the same head presented again is not re-committed
        set_head(1, 6'd5, 2'd0, 5'd3, 32'h1234, 0, 0);
        tick();
        chk("alu_rfv", {31'd0, rf_valid}, 32'd1);
        chk("alu_rd", {27'd0, rf_rd}, 32'd3);
        chk("alu_val", rf_value, 32'h1234);
        chk("alu_pop", {31'd0, head_pop}, 32'd1);
        chk("alu_count", commit_count, 32'd1);
        tick();
        chk("hazard_pop", {31'd0, head_pop}, 32'd0);
        head_valid = 0;
        tick();

        // Store: st_done arrives in the 4th st_commit cycle
        set_head(1, 6'd6, 2'd1, 5'd7, 32'h55, 0, 0);
        tick();
        stc_cnt = int'(st_commit); rfv_seen = int'(rf_valid);
        for (int i = 0; i < 4; i++) begin
            st_done = (i == 3);
            tick();
            if (i < 3) stc_cnt += int'(st_commit);
            rfv_seen += int'(rf_valid);
            if (i < 3) chk("st_early_pop", {31'd0, head_pop}, 32'd0);
        end
        chk("st_cycles", stc_cnt, 32'd4);
        chk("st_no_rfv", rfv_seen, 32'd0);
        chk("st_pop", {31'd0, head_pop}, 32'd1);
        chk("st_release", {31'd0, st_commit}, 32'd0);
        st_done = 0; head_valid = 0;
        tick();

        // Branch mispredict, next head must wait out the flush cycle
        set_head(1, 6'd7, 2'd2, 5'd0, 32'h77, 1, 32'h100);
        tick();
        chk("br_flush", {31'd0, flush}, 32'd1);
        chk("br_pc", redirect_pc, 32'h100);
        set_head(1, 6'd8, 2'd0, 5'd4, 32'h88, 0, 0);
        tick();
        chk("br_gap_flush", {31'd0, flush}, 32'd0);
        chk("br_gap_pop", {31'd0, head_pop}, 32'd0);
        tick();
        chk("br_after_rd", {27'd0, rf_rd}, 32'd4);
        head_valid = 0;
        tick();

        // JALR mispredict: write and flush together
        set_head(1, 6'd9, 2'd3, 5'd1, 32'h48, 1, 32'h200);
        tick();
        chk("jalr_rfv", {31'd0, rf_valid}, 32'd1);
        chk("jalr_flush", {31'd0, flush}, 32'd1);
        chk("jalr_rd", {27'd0, rf_rd}, 32'd1);
        head_valid = 0; head_mispredict = 0;
        tick();

        // Global stall with a ready head
        rdy = 0;
        set_head(1, 6'd10, 2'd0, 5'd2, 32'hA, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_rfv", {31'd0, rf_valid}, 32'd0);
        end
        rdy = 1;
        tick();
        chk("stall_commit", {31'd0, rf_valid}, 32'd1);
        chk("stall_count", commit_count, 32'd6);
        head_valid = 0;
        tick();

        // Reset while waiting on a store
        set_head(1, 6'd11, 2'd1, 5'd0, 32'h0, 0, 0);
        tick();
        chk("rs_stc", {31'd0, st_commit}, 32'd1);
        rst = 1;
        tick();
        chk("rs_stc_off", {31'd0, st_commit}, 32'd0);
        chk("rs_count", commit_count, 32'd0);
        rst = 0;
        set_head(1, 6'd12, 2'd0, 5'd9, 32'h99, 0, 0);
        tick();
        chk("rs_run", {31'd0, rf_valid}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            head_valid = ($urandom_range(0, 3) != 0);
            head_ready = ($urandom_range(0, 2) != 0);
            head_index = 6'($urandom_range(0, 3));
            head_type = 2'($urandom_range(0, 3));
            head_rd = 5'($urandom);
            head_value = $urandom;
            head_mispredict = ($urandom_range(0, 2) == 0);
            head_target = $urandom;
            st_done = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
